// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: frame-synchronous game-flow controller for the runner game.
// Sequences IDLE -> RUN -> DYING -> OVER -> RUN, freezes the world on a hit,
// enables the end-screen overlay, gates restart on the start button and keeps
// the BCD running score and high score for the HUD.
// Optional feature: define GAME_OVER_BLINK_EN to blink the overlay in OVER.
module game_flow_ctrl #(
  parameter int DYING_FRAMES   = 30,
  parameter int LOCKOUT_FRAMES = 60,
  parameter int SCORE_DIV      = 6,
  parameter int BLINK_FRAMES   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_tick,
  input  logic        hit,
  input  logic        btn_start,
  output logic        run_en,
  output logic        clear_world,
  output logic        show_end,
  output logic [1:0]  game_state,
  output logic [15:0] score,
  output logic [15:0] hi_score
);

  // Shared frame-event counter must hold the largest frame count in use
  // (lockout saturates at LOCKOUT_FRAMES itself), and is never narrower than 8.
  localparam int MaxDL     = (DYING_FRAMES > LOCKOUT_FRAMES) ? DYING_FRAMES : LOCKOUT_FRAMES;
  localparam int MaxDS     = (MaxDL > SCORE_DIV) ? MaxDL : SCORE_DIV;
  localparam int MaxFrames = (MaxDS > BLINK_FRAMES) ? MaxDS : BLINK_FRAMES;
  localparam int CntW      = ($clog2(MaxFrames + 1) > 8) ? $clog2(MaxFrames + 1) : 8;

  localparam logic [CntW-1:0] ScoreLast   = CntW'(SCORE_DIV - 1);
  localparam logic [CntW-1:0] DyingLast   = CntW'(DYING_FRAMES - 1);
  localparam logic [CntW-1:0] LockoutDone = CntW'(LOCKOUT_FRAMES);
  localparam logic [15:0]     ScoreMax    = 16'h9999;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DYING = 2'd2,
    OVER  = 2'd3
  } state_t;

  state_t          state;
  logic [CntW-1:0] frameCnt;
  logic            btnMeta;
  logic            btnSync;
  logic            btnPrev;
  logic            press;
  logic            startGame;

  // Increment a 4-digit BCD value with per-digit 9 -> 0 carry.
  function automatic logic [15:0] bcdInc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int d = 0; d < 4; d++) begin
      if (carry) begin
        if (v[4*d +: 4] == 4'd9) begin
          r[4*d +: 4] = 4'd0;
        end else begin
          r[4*d +: 4] = v[4*d +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Synchronize the raw button and register a one-cycle press on its rising edge.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge
  // values; control flops get an async reset, and there is no memory array here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btnMeta <= 1'b0;
      btnSync <= 1'b0;
      btnPrev <= 1'b0;
      press   <= 1'b0;
    end else begin
      btnMeta <= btn_start;
      btnSync <= btnMeta;
      btnPrev <= btnSync;
      press   <= btnSync & ~btnPrev;
    end
  end

  // A press starts a game from IDLE, or from OVER once the lockout has elapsed.
  always_comb begin
    startGame = 1'b0;
    if (press) begin
      if (state == IDLE) begin
        startGame = 1'b1;
      end else if ((state == OVER) && (frameCnt >= LockoutDone)) begin
        startGame = 1'b1;
      end
    end
  end

`ifdef GAME_OVER_BLINK_EN
  localparam logic [CntW-1:0] BlinkLast = CntW'(BLINK_FRAMES - 1);
  logic [CntW-1:0] blinkCnt;
`endif

  // Game-flow FSM with registered outputs, score and high-score tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      frameCnt    <= '0;
      run_en      <= 1'b0;
      clear_world <= 1'b0;
      show_end    <= 1'b0;
      score       <= '0;
      hi_score    <= '0;
`ifdef GAME_OVER_BLINK_EN
      blinkCnt    <= '0;
`endif
    end else begin
      clear_world <= 1'b0;
      if (startGame) begin
        state       <= RUN;
        frameCnt    <= '0;
        run_en      <= 1'b1;
        clear_world <= 1'b1;
        show_end    <= 1'b0;
        score       <= '0;
      end else begin
        case (state)
          RUN: begin
            // A hit freezes the world and beats a same-cycle frame tick.
            if (hit) begin
              state    <= DYING;
              frameCnt <= '0;
              run_en   <= 1'b0;
              if (score > hi_score) begin
                hi_score <= score;
              end
            end else if (frame_tick) begin
              if (frameCnt == ScoreLast) begin
                frameCnt <= '0;
                if (score != ScoreMax) begin
                  score <= bcdInc(score);
                end
              end else begin
                frameCnt <= frameCnt + CntW'(1);
              end
            end
          end
          DYING: begin
            if (frame_tick) begin
              if (frameCnt == DyingLast) begin
                state    <= OVER;
                frameCnt <= '0;
                show_end <= 1'b1;
`ifdef GAME_OVER_BLINK_EN
                blinkCnt <= '0;
`endif
              end else begin
                frameCnt <= frameCnt + CntW'(1);
              end
            end
          end
          OVER: begin
            // Lockout count saturates so a late press is still accepted.
            if (frame_tick && (frameCnt < LockoutDone)) begin
              frameCnt <= frameCnt + CntW'(1);
            end
`ifdef GAME_OVER_BLINK_EN
            if (frame_tick) begin
              if (blinkCnt == BlinkLast) begin
                blinkCnt <= '0;
                show_end <= ~show_end;
              end else begin
                blinkCnt <= blinkCnt + CntW'(1);
              end
            end
`endif
          end
          default: begin
            // IDLE waits for a press, handled by startGame.
          end
        endcase
      end
    end
  end

  assign game_state = state;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// tb_game_flow_ctrl: scoreboard bench for game_flow_ctrl. Expected output
// snapshots are queued as stimulus is driven and compared when sampled.
// A second instance with SCORE_DIV=1 reaches the 9999 score ceiling quickly.
module tb_game_flow_ctrl;

  localparam int BLINK_FRAMES = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_tick;
  logic        hit;
  logic        btn_start;
  logic        run_en;
  logic        clear_world;
  logic        show_end;
  logic [1:0]  game_state;
  logic [15:0] score;
  logic [15:0] hi_score;

  logic        satTick;
  logic        satHit;
  logic        satBtn;
  logic        satRunEn;
  logic        satClear;
  logic        satShow;
  logic [1:0]  satState;
  logic [15:0] satScore;
  logic [15:0] satHi;

  int nChecks = 0;
  int nFails  = 0;

  typedef struct {
    string       tag;
    logic [1:0]  st;
    logic        re;
    logic        cw;
    logic        se;
    logic [15:0] sc;
    logic [15:0] hi;
  } exp_t;

  exp_t expQ[$];

  game_flow_ctrl #(
    .DYING_FRAMES  (30),
    .LOCKOUT_FRAMES(60),
    .SCORE_DIV     (6),
    .BLINK_FRAMES  (BLINK_FRAMES)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .hit        (hit),
    .btn_start  (btn_start),
    .run_en     (run_en),
    .clear_world(clear_world),
    .show_end   (show_end),
    .game_state (game_state),
    .score      (score),
    .hi_score   (hi_score)
  );

  game_flow_ctrl #(
    .DYING_FRAMES  (30),
    .LOCKOUT_FRAMES(60),
    .SCORE_DIV     (1),
    .BLINK_FRAMES  (BLINK_FRAMES)
  ) dutSat (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (satTick),
    .hit        (satHit),
    .btn_start  (satBtn),
    .run_en     (satRunEn),
    .clear_world(satClear),
    .show_end   (satShow),
    .game_state (satState),
    .score      (satScore),
    .hi_score   (satHi)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    nChecks++;
    if (observed !== expected) begin
      nFails++;
      $display("FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic expectOut(input string tag, input logic [1:0] st, input logic re, input logic cw,
                           input logic se, input logic [15:0] sc, input logic [15:0] hi);
    exp_t e;
    e.tag = tag;
    e.st  = st;
    e.re  = re;
    e.cw  = cw;
    e.se  = se;
    e.sc  = sc;
    e.hi  = hi;
    expQ.push_back(e);
  endtask

  task automatic compareOut();
    exp_t e;
    e = expQ.pop_front();
    check({e.tag, ".game_state"},  {14'd0, game_state}, {14'd0, e.st});
    check({e.tag, ".run_en"},      {15'd0, run_en},      {15'd0, e.re});
    check({e.tag, ".clear_world"}, {15'd0, clear_world}, {15'd0, e.cw});
    check({e.tag, ".show_end"},    {15'd0, show_end},    {15'd0, e.se});
    check({e.tag, ".score"},       score,                e.sc);
    check({e.tag, ".hi_score"},    hi_score,             e.hi);
  endtask

  // Expected overlay level after n frame ticks inside OVER.
  function automatic logic expShow(input int n);
`ifdef GAME_OVER_BLINK_EN
    return ((n / BLINK_FRAMES) % 2) == 0;
`else
    return (n >= 0);
`endif
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // n frame ticks: one cycle high, two cycles low each.
  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      cycles(1);
      frame_tick = 1'b0;
      cycles(2);
    end
  endtask

  // Button press expected to be ignored: held 5 cycles, then released.
  task automatic ignoredPress();
    btn_start = 1'b1;
    cycles(5);
    btn_start = 1'b0;
    cycles(2);
  endtask

  // Button press expected to start a game 4 cycles after the pin rises.
  task automatic startPress(input string tag, input logic [15:0] hi);
    btn_start = 1'b1;
    cycles(3);
    expectOut(tag, 2'd1, 1'b1, 1'b1, 1'b0, 16'h0000, hi);
    cycles(1);
    compareOut();
    cycles(1);
    btn_start = 1'b0;
    cycles(1);
  endtask

  initial begin
    rst_n      = 1'b0;
    frame_tick = 1'b0;
    hit        = 1'b0;
    btn_start  = 1'b0;
    satTick    = 1'b0;
    satHit     = 1'b0;
    satBtn     = 1'b0;
    cycles(2);
    expectOut("reset", 2'd0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    compareOut();
    rst_n = 1'b1;
    cycles(2);

    // First start: pin -> press 3 cycles, press -> RUN 1 cycle.
    btn_start = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      expectOut($sformatf("press_latency%0d", i), 2'd0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
      cycles(1);
      compareOut();
    end
    expectOut("run_entry", 2'd1, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000);
    cycles(1);
    compareOut();
    expectOut("clear_once", 2'd1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    cycles(1);
    compareOut();
    btn_start = 1'b0;
    cycles(2);

    // Game 1: score to 4, then hit on the 6th tick of the next group.
    frames(6);
    expectOut("score_6frames", 2'd1, 1'b1, 1'b0, 1'b0, 16'h0001, 16'h0000);
    compareOut();
    frames(18);
    expectOut("score_24frames", 2'd1, 1'b1, 1'b0, 1'b0, 16'h0004, 16'h0000);
    compareOut();
    frames(5);
    frame_tick = 1'b1;
    hit        = 1'b1;
    expectOut("hit_beats_tick", 2'd2, 1'b0, 1'b0, 1'b0, 16'h0004, 16'h0004);
    cycles(1);
    compareOut();
    frame_tick = 1'b0;
    cycles(2);
    hit = 1'b0;

    // DYING ignores press and hit; OVER after the 30th tick.
    ignoredPress();
    expectOut("dying_press_ignored", 2'd2, 1'b0, 1'b0, 1'b0, 16'h0004, 16'h0004);
    compareOut();
    frames(29);
    expectOut("dying_29", 2'd2, 1'b0, 1'b0, 1'b0, 16'h0004, 16'h0004);
    compareOut();
    frame_tick = 1'b1;
    expectOut("over_entry", 2'd3, 1'b0, 1'b0, 1'b1, 16'h0004, 16'h0004);
    cycles(1);
    compareOut();
    frame_tick = 1'b0;
    cycles(2);

    // OVER: overlay level and restart lockout.
    frames(15);
    expectOut("over_15", 2'd3, 1'b0, 1'b0, expShow(15), 16'h0004, 16'h0004);
    compareOut();
    frames(1);
    expectOut("over_16", 2'd3, 1'b0, 1'b0, expShow(16), 16'h0004, 16'h0004);
    compareOut();
    frames(16);
    expectOut("over_32", 2'd3, 1'b0, 1'b0, expShow(32), 16'h0004, 16'h0004);
    compareOut();
    frames(27);
    ignoredPress();
    expectOut("lockout_59_press", 2'd3, 1'b0, 1'b0, expShow(59), 16'h0004, 16'h0004);
    compareOut();
    frames(1);
    expectOut("press_not_queued", 2'd3, 1'b0, 1'b0, expShow(60), 16'h0004, 16'h0004);
    compareOut();
    startPress("restart_60", 16'h0004);

    // Game 2 ends lower: high score kept.
    frames(12);
    expectOut("game2_score", 2'd1, 1'b1, 1'b0, 1'b0, 16'h0002, 16'h0004);
    compareOut();
    hit = 1'b1;
    expectOut("game2_hit", 2'd2, 1'b0, 1'b0, 1'b0, 16'h0002, 16'h0004);
    cycles(1);
    compareOut();
    hit = 1'b0;
    frames(30);
    expectOut("game2_over", 2'd3, 1'b0, 1'b0, 1'b1, 16'h0002, 16'h0004);
    compareOut();
    frames(60);
    startPress("restart_game3", 16'h0004);

    // Game 3 beats the high score.
    frames(60);
    expectOut("score_60frames", 2'd1, 1'b1, 1'b0, 1'b0, 16'h0010, 16'h0004);
    compareOut();
    hit = 1'b1;
    expectOut("game3_hit", 2'd2, 1'b0, 1'b0, 1'b0, 16'h0010, 16'h0010);
    cycles(1);
    compareOut();
    hit = 1'b0;
    frames(35);

    // Asynchronous reset mid-OVER clears outputs before the next edge.
    #2;
    rst_n = 1'b0;
    #1;
    expectOut("async_reset", 2'd0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    compareOut();
    cycles(1);
    rst_n = 1'b1;
    cycles(2);

    // Saturation instance: one increment per tick.
    satBtn = 1'b1;
    cycles(5);
    satBtn = 1'b0;
    check("sat_state_run", {14'd0, satState}, 16'd1);
    satTick = 1'b1;
    cycles(1000);
    check("sat_score_1000", satScore, 16'h1000);
    cycles(8999);
    check("sat_score_9999", satScore, 16'h9999);
    cycles(6);
    check("sat_score_hold", satScore, 16'h9999);
    satTick = 1'b0;
    satHit  = 1'b1;
    cycles(1);
    satHit  = 1'b0;
    check("sat_hi_score", satHi, 16'h9999);
    check("sat_state_dying", {14'd0, satState}, 16'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
